// File: rtl/fc_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fc_sched_pkg
//  Description : Shared constants, state encoding and frame builder for the
//                fast command scheduler.
//                Contents: frame width, frame header, idle frame, scheduler
//                state enum and make_frame().
//  Revision    : 1.0 - initial release
// ============================================================================
package fc_sched_pkg;

    localparam int         FRAME_W    = 8;
    localparam logic [2:0] FRAME_HDR  = 3'b110;
    localparam logic [7:0] IDLE_FRAME = 8'b1100_0001;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_ALIGN    = 2'd1,
        ST_RUN      = 2'd2,
        ST_DRAIN    = 2'd3
    } state_t;

    // Every frame is header, 4-bit command, trailing 1.
    function automatic logic [FRAME_W-1:0] make_frame(input logic [3:0] c);
        return {FRAME_HDR, c, 1'b1};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fast_command_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : fast_command_scheduler_if
//  Description : Requester bus of the fast command scheduler.
//                req  : per-requester request level
//                cmd  : per-requester 4-bit command, requester i on [4i+3:4i]
//                ack  : one-cycle grant pulse, one-hot or zero
//                master = requester side, slave = scheduler side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fast_command_scheduler_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [4*NREQ-1:0] cmd;
    logic [NREQ-1:0]   ack;

    modport master (output req, output cmd, input  ack);
    modport slave  (input  req, input  cmd, output ack);
endinterface
`default_nettype wire

// File: rtl/fc_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fc_rr_arbiter
//  Description : Combinational round-robin arbiter.
//                req   (in)  : request vector
//                ptr   (in)  : highest-priority index this round
//                grant (out) : one-hot grant, zero when nothing requested
//                valid (out) : a grant was issued
//  Revision    : 1.0 - initial release
// ============================================================================
module fc_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  wire logic [NREQ-1:0] req,
    input  wire logic [PW-1:0]   ptr,
    output logic      [NREQ-1:0] grant,
    output logic                 valid
);

    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        // First pass: indices at or above the pointer.
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
        // Second pass wraps to the indices below the pointer.
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
        valid = found;
    end

endmodule
`default_nettype wire

// File: rtl/fast_command_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : fast_command_scheduler
//  Description : Serialises 8-bit fast-command frames, MSB first, one frame
//                every 8 clocks. In RUN each frame slot carries the orbit
//                command (orbit frame 0), a round-robin granted requester
//                command, or an idle frame.
//                sel_fast_clock (in)  : bit clock, rising edge
//                arstn          (in)  : asynchronous active-low reset
//                enable         (in)  : schedule requests when high
//                orbit_enable   (in)  : insert ORBIT_CMD at orbit frame 0
//                bus            (if)  : req/cmd in, ack out
//                fast_command_out(out): serial frame stream
//                frame_start    (out) : high while frame bit 7 is on the line
//                orbit_count    (out) : orbit frame index
//                deferred_count (out) : saturating count of deferred loads
//  Revision    : 1.0 - initial release
// ============================================================================
module fast_command_scheduler
    import fc_sched_pkg::*;
#(
    parameter int          NREQ         = 4,
    parameter int unsigned ORBIT_FRAMES = 3564,
    parameter logic [3:0]  ORBIT_CMD    = 4'b0001
) (
    input  wire logic              sel_fast_clock,
    input  wire logic              arstn,
    input  wire logic              enable,
    input  wire logic              orbit_enable,
    fast_command_scheduler_if.slave bus,
    output logic                   fast_command_out,
    output logic                   frame_start,
    output logic [15:0]            orbit_count,
    output logic [15:0]            deferred_count
);

    localparam int          PW         = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [15:0] ORBIT_LAST = 16'(ORBIT_FRAMES - 1);

    if (ORBIT_CMD == 4'b0000) begin : g_bad_orbit_cmd
        $error("ORBIT_CMD must differ from the idle command 4'b0000");
    end
    if ((NREQ < 1) || (NREQ > 8)) begin : g_bad_nreq
        $error("NREQ must be within 1..8");
    end

    state_t               state_q, state_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic                 fc_out_q, fc_out_d;
    logic                 frame_start_q, frame_start_d;
    logic [15:0]          orbit_count_q, orbit_count_d;
    logic [15:0]          deferred_q, deferred_d;
    logic [PW-1:0]        rr_ptr_q, rr_ptr_d;

    logic [NREQ-1:0]      grant;
    logic                 grant_valid;
    logic [PW-1:0]        grant_idx;
    logic [3:0]           grant_cmd;
    logic [NREQ-1:0]      ack_c;
    logic [15:0]          orbit_next;
    logic                 load;

    fc_rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .req   (bus.req),
        .ptr   (rr_ptr_q),
        .grant (grant),
        .valid (grant_valid)
    );

    always_comb begin
        grant_idx = '0;
        grant_cmd = 4'h0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                grant_idx = PW'(i);
                grant_cmd = bus.cmd[4*i +: 4];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q + 3'd1;
        frame_d       = {frame_q[FRAME_W-2:0], 1'b0};
        fc_out_d      = frame_q[FRAME_W-1];
        // Bit 7 sits in frame_q during count 0 and reaches the output pin
        // one clock later, so frame_start is registered from count 0 too.
        frame_start_d = (bit_cnt_q == 3'd0);
        orbit_count_d = orbit_count_q;
        deferred_d    = deferred_q;
        rr_ptr_d      = rr_ptr_q;
        ack_c         = '0;
        load          = (bit_cnt_q == 3'd7);
        orbit_next    = (orbit_count_q == ORBIT_LAST) ? 16'd0
                                                      : orbit_count_q + 16'd1;

        if (load) begin
            frame_d = IDLE_FRAME;
        end

        case (state_q)
            ST_DISABLED: begin
                orbit_count_d = 16'd0;
                if (enable) begin
                    state_d = ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                orbit_count_d = 16'd0;
                if (!enable) begin
                    state_d = ST_DISABLED;
                end else if (load) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (load) begin
                    // A load coinciding with enable falling is still
                    // scheduled normally; DRAIN starts afterwards.
                    orbit_count_d = orbit_next;
                    if (orbit_enable && (orbit_next == 16'd0)) begin
                        frame_d = make_frame(ORBIT_CMD);
                        if ((|bus.req) && (deferred_q != 16'hFFFF)) begin
                            deferred_d = deferred_q + 16'd1;
                        end
                    end else if (grant_valid) begin
                        frame_d  = make_frame(grant_cmd);
                        ack_c    = grant;
                        rr_ptr_d = (grant_idx == PW'(NREQ - 1)) ? '0
                                                                : grant_idx + PW'(1);
                    end
                    if (!enable) begin
                        state_d = ST_DRAIN;
                    end
                end else if (!enable) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                orbit_count_d = 16'd0;
                if (load) begin
                    state_d = ST_DISABLED;
                end
            end
            default: begin
                state_d = ST_DISABLED;
            end
        endcase
    end

    always_ff @(posedge sel_fast_clock or negedge arstn) begin
        if (!arstn) begin
            state_q       <= ST_DISABLED;
            bit_cnt_q     <= 3'd0;
            frame_q       <= IDLE_FRAME;
            fc_out_q      <= 1'b0;
            frame_start_q <= 1'b0;
            orbit_count_q <= 16'd0;
            deferred_q    <= 16'd0;
            rr_ptr_q      <= '0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            frame_q       <= frame_d;
            fc_out_q      <= fc_out_d;
            frame_start_q <= frame_start_d;
            orbit_count_q <= orbit_count_d;
            deferred_q    <= deferred_d;
            rr_ptr_q      <= rr_ptr_d;
        end
    end

    assign bus.ack          = ack_c;
    assign fast_command_out = fc_out_q;
    assign frame_start      = frame_start_q;
    assign orbit_count      = orbit_count_q;
    assign deferred_count   = deferred_q;

endmodule
`default_nettype wire
